// File: rtl/pattern_pkg.sv
// Shared definitions for the "101" pattern generator and its detector models:
// pattern length, FSM state encoding and the word build / detect / conflict helpers.
package pattern_pkg;

    localparam int PAT_LEN = 3;
    // Widest word the helpers handle; callers zero-extend into it and truncate back.
    localparam int MAX_W   = 64;

    typedef logic [MAX_W-1:0] vec_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT
    } state_t;

    // "101" at index i sets bits i and i+2; bit i+1 stays at the background 0.
    function automatic vec_t build_word(input vec_t mask);
        return mask | (mask << (PAT_LEN - 1));
    endfunction

    // detect[i] = w[i] & ~w[i+1] & w[i+2]; bits shifted in from above are 0.
    function automatic vec_t detect_101(input vec_t w);
        return w & ~(w >> 1) & (w >> 2);
    endfunction

    // Adjacent mask bits demand both a 1 and a 0 at the same word bit.
    function automatic logic has_conflict(input vec_t mask);
        return |(mask & (mask >> 1));
    endfunction

endpackage

// File: rtl/pattern_stream_generator_if.sv
// Request, result and serial-stream signals of the pattern stream generator.
// master = generator side, slave = requester / serial sink side.
interface pattern_stream_generator_if
    import pattern_pkg::*;
#(
    parameter int WIDTH = 16
);
    localparam int MASK_W = WIDTH - PAT_LEN + 1;

    logic              req_valid;
    logic              req_ready;
    logic [MASK_W-1:0] req_mask;
    logic [WIDTH-1:0]  word_out;
    logic              word_valid;
    logic              exact;
    logic              err_conflict;
    logic              ser_data;
    logic              ser_valid;
    logic              ser_ready;
    logic              ser_last;
    logic              busy;

    modport master (
        input  req_valid, req_mask, ser_ready,
        output req_ready, word_out, word_valid, exact, err_conflict,
               ser_data, ser_valid, ser_last, busy
    );

    modport slave (
        output req_valid, req_mask, ser_ready,
        input  req_ready, word_out, word_valid, exact, err_conflict,
               ser_data, ser_valid, ser_last, busy
    );

endinterface

// File: rtl/pattern_word_builder.sv
// Combinational word builder: mask -> data word, conflict flag and the match
// mask a "101" detector would report for that word.
module pattern_word_builder
    import pattern_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-PAT_LEN:0] mask,
    output logic [WIDTH-1:0]       word,
    output logic                   conflict,
    output logic [WIDTH-PAT_LEN:0] detected
);

    // Build the word and re-detect it for the round-trip comparison.
    always_comb begin
        // NOTE: every output is assigned unconditionally, so no latch can be inferred.
        word     = WIDTH'(build_word(vec_t'(mask)));
        conflict = has_conflict(vec_t'(mask));
        detected = (WIDTH-PAT_LEN+1)'(detect_101(vec_t'(word)));
    end

endmodule

// File: rtl/pattern_stream_generator.sv
// Accepts a match-index mask, builds the "101" data word in one LOAD cycle,
// then serialises it bit by bit over a valid/ready stream.
module pattern_stream_generator
    import pattern_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter bit MSB_FIRST = 1'b0
) (
    input logic                        clk,
    input logic                        reset,
    pattern_stream_generator_if.master bus
);

    localparam int MASK_W = WIDTH - PAT_LEN + 1;
    localparam int CNT_W  = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t            state;
    logic [MASK_W-1:0] mask_q;
    logic [WIDTH-1:0]  word_q;
    logic [CNT_W-1:0]  cnt;
    logic              req_ready_q;
    logic              word_valid_q;
    logic              exact_q;
    logic              err_q;
    logic              ser_data_q;
    logic              ser_valid_q;
    logic              ser_last_q;
    logic              busy_q;

    logic [WIDTH-1:0]  built_word;
    logic              conflict;
    logic [MASK_W-1:0] detected;

    pattern_word_builder #(.WIDTH(WIDTH)) u_builder (
        .mask     (mask_q),
        .word     (built_word),
        .conflict (conflict),
        .detected (detected)
    );

    // Word bit sent at serial position c.
    function automatic logic [CNT_W-1:0] bit_idx(input logic [CNT_W-1:0] c);
        return MSB_FIRST ? CNT_LAST - c : c;
    endfunction

    // FSM, counter, shifter and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            mask_q       <= '0;
            word_q       <= '0;
            cnt          <= '0;
            req_ready_q  <= 1'b0;
            word_valid_q <= 1'b0;
            exact_q      <= 1'b0;
            err_q        <= 1'b0;
            ser_data_q   <= 1'b0;
            ser_valid_q  <= 1'b0;
            ser_last_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout; a later assignment in the
            // same cycle overrides these pulse defaults.
            word_valid_q <= 1'b0;
            err_q        <= 1'b0;
            case (state)
                IDLE: begin
                    req_ready_q <= 1'b1;
                    if (bus.req_valid && req_ready_q) begin
                        mask_q      <= bus.req_mask;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state       <= LOAD;
                    end
                end
                LOAD: begin
                    word_q       <= built_word;
                    word_valid_q <= 1'b1;
                    exact_q      <= !conflict && (detected == mask_q);
                    if (conflict) begin
                        err_q       <= 1'b1;
                        req_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        cnt         <= '0;
                        ser_valid_q <= 1'b1;
                        ser_data_q  <= built_word[bit_idx('0)];
                        ser_last_q  <= 1'b0;
                        state       <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (ser_valid_q && bus.ser_ready) begin
                        if (cnt == CNT_LAST) begin
                            ser_valid_q <= 1'b0;
                            ser_data_q  <= 1'b0;
                            ser_last_q  <= 1'b0;
                            req_ready_q <= 1'b1;
                            busy_q      <= 1'b0;
                            state       <= IDLE;
                        end else begin
                            cnt        <= cnt + 1'b1;
                            ser_data_q <= word_q[bit_idx(cnt + 1'b1)];
                            ser_last_q <= ((cnt + 1'b1) == CNT_LAST);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready    = req_ready_q;
    assign bus.word_out     = word_q;
    assign bus.word_valid   = word_valid_q;
    assign bus.exact        = exact_q;
    assign bus.err_conflict = err_q;
    assign bus.ser_data     = ser_data_q;
    assign bus.ser_valid    = ser_valid_q;
    assign bus.ser_last     = ser_last_q;
    assign bus.busy         = busy_q;

endmodule

// File: tb/tb_pattern_stream_generator.sv
// Directed bench for pattern_stream_generator (WIDTH=16, LSB first):
// a table of masks with hand-computed words, plus reset corner sequences.
module tb_pattern_stream_generator;

    logic clk;
    logic reset;

    pattern_stream_generator_if #(.WIDTH(16)) bus ();

    pattern_stream_generator #(.WIDTH(16), .MSB_FIRST(1'b0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [13:0] mask;
        logic [15:0] word;
        logic        exact;
        logic        conflict;
        bit          toggle;
    } tv_t;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One full request: accept, LOAD, word result, serial drain.
    task automatic do_req(input tv_t tv);
        int          budget;
        int          nbits;
        int          nlast;
        int          last_pos;
        int          stall_err;
        int          wv_extra;
        logic [15:0] ser_word;
        logic        prev_data;
        logic        prev_last;
        bit          stalled;
        bit          rdy;

        budget = 0;
        while (!bus.req_ready && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        check("req_ready_wait", bus.req_ready, 1'b1);

        bus.req_valid = 1'b1;
        bus.req_mask  = tv.mask;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_mask  = '0;
        check("load_busy", bus.busy, 1'b1);
        check("load_req_ready", bus.req_ready, 1'b0);
        check("load_word_valid", bus.word_valid, 1'b0);

        @(negedge clk);
        check("word_valid", bus.word_valid, 1'b1);
        check("word_out", bus.word_out, tv.word);
        check("exact", bus.exact, tv.exact);
        check("err_conflict", bus.err_conflict, tv.conflict);
        check("first_ser_valid", bus.ser_valid, !tv.conflict);
        if (tv.conflict)
            check("conflict_req_ready", bus.req_ready, 1'b1);

        nbits = 0; nlast = 0; last_pos = -1; stall_err = 0; wv_extra = 0;
        ser_word = '0; stalled = 1'b0; prev_data = 1'b0; prev_last = 1'b0;
        for (int c = 0; c < 100 && bus.ser_valid; c++) begin
            rdy = tv.toggle ? (c % 2 == 0) : 1'b1;
            bus.ser_ready = rdy;
            // Requests during SHIFT must be ignored.
            bus.req_valid = 1'b1;
            bus.req_mask  = 14'h0002;
            if (c > 0 && bus.word_valid) wv_extra++;
            if (stalled && (bus.ser_data !== prev_data || bus.ser_last !== prev_last))
                stall_err++;
            if (rdy) begin
                if (nbits < 16) ser_word[nbits] = bus.ser_data;
                if (bus.ser_last) begin
                    nlast++;
                    last_pos = nbits;
                end
                nbits++;
            end
            stalled   = !rdy;
            prev_data = bus.ser_data;
            prev_last = bus.ser_last;
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        bus.req_mask  = '0;
        bus.ser_ready = 1'b0;

        check("ser_done", bus.ser_valid, 1'b0);
        check("end_req_ready", bus.req_ready, 1'b1);
        check("end_busy", bus.busy, 1'b0);
        check("word_held", bus.word_out, tv.word);
        check("word_valid_once", wv_extra, 0);
        if (tv.conflict) begin
            check("conflict_no_bits", nbits, 0);
        end else begin
            check("ser_word", ser_word, tv.word);
            check("ser_nbits", nbits, 16);
            check("ser_last_count", nlast, 1);
            check("ser_last_pos", last_pos, 15);
            check("ser_stall_stable", stall_err, 0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_word_out"}, bus.word_out, 16'h0000);
        check({tag, "_word_valid"}, bus.word_valid, 1'b0);
        check({tag, "_exact"}, bus.exact, 1'b0);
        check({tag, "_err"}, bus.err_conflict, 1'b0);
        check({tag, "_ser_valid"}, bus.ser_valid, 1'b0);
        check({tag, "_ser_data"}, bus.ser_data, 1'b0);
        check({tag, "_ser_last"}, bus.ser_last, 1'b0);
        check({tag, "_busy"}, bus.busy, 1'b0);
    endtask

    tv_t vecs[8];

    initial begin
        vecs[0] = '{mask: 14'h0001, word: 16'h0005, exact: 1'b1, conflict: 1'b0, toggle: 1'b0};
        vecs[1] = '{mask: 14'h0005, word: 16'h0015, exact: 1'b1, conflict: 1'b0, toggle: 1'b0};
        vecs[2] = '{mask: 14'h0003, word: 16'h000F, exact: 1'b0, conflict: 1'b1, toggle: 1'b0};
        vecs[3] = '{mask: 14'h0011, word: 16'h0055, exact: 1'b0, conflict: 1'b0, toggle: 1'b0};
        vecs[4] = '{mask: 14'h2000, word: 16'hA000, exact: 1'b1, conflict: 1'b0, toggle: 1'b1};
        vecs[5] = '{mask: 14'h0000, word: 16'h0000, exact: 1'b1, conflict: 1'b0, toggle: 1'b0};
        vecs[6] = '{mask: 14'h1555, word: 16'h5555, exact: 1'b1, conflict: 1'b0, toggle: 1'b0};
        vecs[7] = '{mask: 14'h3000, word: 16'hF000, exact: 1'b0, conflict: 1'b1, toggle: 1'b0};

        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_mask  = '0;
        bus.ser_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_req_ready", bus.req_ready, 1'b1);

        for (int i = 0; i < 8; i++)
            do_req(vecs[i]);

        // Reset in the middle of SHIFT at cnt=7.
        bus.req_valid = 1'b1;
        bus.req_mask  = 14'h0001;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_mask  = '0;
        @(negedge clk);
        bus.ser_ready = 1'b1;
        repeat (7) @(negedge clk);
        check("midop_ser_valid", bus.ser_valid, 1'b1);
        check("midop_busy", bus.busy, 1'b1);
        #2 reset = 1'b1;
        #1 check_all_zero("midop_reset");
        bus.ser_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        do_req(vecs[0]);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
